// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: grants one of N_REQ requesters a capped burst on a shared bus,
// round-robin or fixed priority, forwarding the owner's data as registered beats.
module rr_bus_arbiter #(
    parameter int N_REQ     = 4,
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*W-1:0]       req_data,
    input  logic                     prio_mode,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic [W-1:0]             bus_out,
    output logic                     bus_valid
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [IDW-1:0]  last_id, last_id_nxt, gnt_id_nxt, win;
    logic [N_REQ-1:0] gnt_nxt;
    logic [W-1:0]    bus_out_nxt;
    logic            bus_valid_nxt, own_req, last_beat;

    // Fixed mode scans from index 0; round-robin scans from last_id+1 with wrap.
    function automatic logic [IDW-1:0] pick(input logic [N_REQ-1:0] r,
                                            input logic [IDW-1:0] last,
                                            input logic fixed);
        logic [IDW-1:0] id, sel;
        logic           found;
        id    = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            sel = fixed ? IDW'(k) : IDW'((int'(last) + 1 + k) % N_REQ);
            if (!found && r[sel]) begin
                found = 1'b1;
                id    = sel;
            end
        end
        return id;
    endfunction

    assign win       = pick(req, last_id, prio_mode);
    assign own_req   = req[gnt_id];
    assign last_beat = cnt == CW'(MAX_BURST - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            last_id   <= IDW'(N_REQ - 1);
            gnt       <= '0;
            gnt_id    <= '0;
            bus_out   <= '0;
            bus_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            last_id   <= last_id_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            bus_out   <= bus_out_nxt;
            bus_valid <= bus_valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state == IDLE ? (|req ? OWN : IDLE)
                                  : (own_req && !last_beat ? OWN : IDLE);
    end

    always_comb begin
        cnt_nxt       = cnt;
        last_id_nxt   = last_id;
        gnt_nxt       = gnt;
        gnt_id_nxt    = gnt_id;
        bus_out_nxt   = bus_out;
        bus_valid_nxt = 1'b0;
        if (state == IDLE) begin
            if (|req) begin
                gnt_nxt    = N_REQ'(1) << win;
                gnt_id_nxt = win;
                cnt_nxt    = '0;
            end
        end else if (own_req) begin
            bus_out_nxt   = req_data[gnt_id*W +: W];
            bus_valid_nxt = 1'b1;
            cnt_nxt       = last_beat ? cnt : cnt + CW'(1);
            if (last_beat) begin
                gnt_nxt     = '0;
                last_id_nxt = gnt_id;
            end
        end else begin
            gnt_nxt     = '0;
            last_id_nxt = gnt_id;
        end
    end
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter: directed checks of burst timing, both policies, early release,
// asynchronous reset and a small non-power-of-two configuration.
module tb_rr_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic        prio_mode = 1'b0;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic [7:0]  bus_out;
    logic        bus_valid;

    logic [2:0]  req2 = '0;
    logic [47:0] req_data2 = '0;
    logic [2:0]  gnt2;
    logic [1:0]  gnt_id2;
    logic [15:0] bus_out2;
    logic        bus_valid2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_bus_arbiter #(.N_REQ(4), .W(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .prio_mode(prio_mode),
        .gnt(gnt), .gnt_id(gnt_id), .bus_out(bus_out), .bus_valid(bus_valid)
    );

    rr_bus_arbiter #(.N_REQ(3), .W(16), .MAX_BURST(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .req_data(req_data2), .prio_mode(1'b0),
        .gnt(gnt2), .gnt_id(gnt_id2), .bus_out(bus_out2), .bus_valid(bus_valid2)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (gnt !== 4'b0 || gnt_id !== 2'd0 || bus_out !== 8'h00 || bus_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset: gnt=%b id=%0d bus=%h v=%b, want 0000 0 00 0", gnt, gnt_id, bus_out, bus_valid);
        end
        n_cmp++;
        if (gnt2 !== 3'b0 || bus_valid2 !== 1'b0 || bus_out2 !== 16'h0) begin
            n_err++;
            $display("FAIL reset2: gnt=%b bus=%h v=%b, want 000 0000 0", gnt2, bus_out2, bus_valid2);
        end
    endtask

    task automatic test_single_burst();
        rst_n = 1'b1;
        req = 4'b0001;
        req_data = 32'h0000_00A5;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0 || bus_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_grant: gnt=%b id=%0d v=%b, want 0001 0 0", gnt, gnt_id, bus_valid);
        end
        for (int b = 0; b < 4; b++) begin
            tick();
            n_cmp++;
            if (bus_valid !== 1'b1 || bus_out !== 8'hA5 || gnt !== (b == 3 ? 4'b0000 : 4'b0001)) begin
                n_err++;
                $display("FAIL single_beat%0d: v=%b bus=%h gnt=%b, want 1 a5 %b", b, bus_valid, bus_out, gnt,
                         b == 3 ? 4'b0000 : 4'b0001);
            end
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b0001 || bus_valid !== 1'b0 || bus_out !== 8'hA5) begin
            n_err++;
            $display("FAIL single_regrant: gnt=%b v=%b bus=%h, want 0001 0 a5", gnt, bus_valid, bus_out);
        end
        req = 4'b0000;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000 || bus_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_release: gnt=%b v=%b, want 0000 0", gnt, bus_valid);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [7:0] data [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
        do_reset();
        prio_mode = 1'b0;
        req = 4'b1111;
        req_data = 32'h4030_2010;
        for (int g = 0; g < 5; g++) begin
            tick();
            n_cmp++;
            if (gnt !== (4'b0001 << order[g]) || gnt_id !== 2'(order[g])) begin
                n_err++;
                $display("FAIL rr_grant%0d: gnt=%b id=%0d, want id %0d", g, gnt, gnt_id, order[g]);
            end
            for (int b = 0; b < 4; b++) begin
                tick();
                n_cmp++;
                if (bus_valid !== 1'b1 || bus_out !== data[order[g]]) begin
                    n_err++;
                    $display("FAIL rr_beat%0d_%0d: v=%b bus=%h, want 1 %h", g, b, bus_valid, bus_out, data[order[g]]);
                end
            end
        end
    endtask

    task automatic test_fixed_priority();
        prio_mode = 1'b1;
        req = 4'b1010;
        for (int g = 0; g < 3; g++) begin
            tick();
            n_cmp++;
            if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
                n_err++;
                $display("FAIL fp_grant%0d: gnt=%b id=%0d, want 0010 1", g, gnt, gnt_id);
            end
            for (int b = 0; b < 4; b++) begin
                tick();
                n_cmp++;
                if (bus_valid !== 1'b1 || bus_out !== 8'h20) begin
                    n_err++;
                    $display("FAIL fp_beat%0d_%0d: v=%b bus=%h, want 1 20", g, b, bus_valid, bus_out);
                end
            end
        end
    endtask

    task automatic test_early_release();
        prio_mode = 1'b0;
        req = 4'b0100;
        tick();
        n_cmp++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
            n_err++;
            $display("FAIL er_grant: gnt=%b id=%0d, want 0100 2", gnt, gnt_id);
        end
        tick();
        tick();
        n_cmp++;
        if (bus_valid !== 1'b1 || bus_out !== 8'h30) begin
            n_err++;
            $display("FAIL er_beat2: v=%b bus=%h, want 1 30", bus_valid, bus_out);
        end
        req = 4'b1001;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000 || bus_valid !== 1'b0 || bus_out !== 8'h30) begin
            n_err++;
            $display("FAIL er_release: gnt=%b v=%b bus=%h, want 0000 0 30", gnt, bus_valid, bus_out);
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            n_err++;
            $display("FAIL er_next: gnt=%b id=%0d, want 1000 3", gnt, gnt_id);
        end
    endtask

    task automatic test_async_reset();
        tick();
        tick();
        n_cmp++;
        if (bus_valid !== 1'b1 || bus_out !== 8'h40) begin
            n_err++;
            $display("FAIL ar_beat2: v=%b bus=%h, want 1 40", bus_valid, bus_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== 4'b0000 || bus_valid !== 1'b0 || bus_out !== 8'h00 || gnt_id !== 2'd0) begin
            n_err++;
            $display("FAIL ar_async: gnt=%b v=%b bus=%h id=%0d, want 0000 0 00 0", gnt, bus_valid, bus_out, gnt_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1000;
        tick();
        n_cmp++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            n_err++;
            $display("FAIL ar_regrant: gnt=%b id=%0d, want 1000 3", gnt, gnt_id);
        end
        req = 4'b0000;
        tick();
        do_reset();
        req = 4'b1111;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL ar_restart0: gnt=%b, want 0001", gnt);
        end
        req = 4'b0000;
    endtask

    task automatic test_sweep();
        int order [4] = '{0, 1, 2, 0};
        logic [15:0] data [3] = '{16'h1111, 16'h2222, 16'h3333};
        do_reset();
        req2 = 3'b111;
        req_data2 = 48'h3333_2222_1111;
        for (int g = 0; g < 4; g++) begin
            tick();
            n_cmp++;
            if (gnt2 !== (3'b001 << order[g]) || gnt_id2 !== 2'(order[g]) || bus_valid2 !== 1'b0) begin
                n_err++;
                $display("FAIL sw_grant%0d: gnt=%b id=%0d v=%b, want id %0d v 0", g, gnt2, gnt_id2, bus_valid2, order[g]);
            end
            tick();
            n_cmp++;
            if (bus_valid2 !== 1'b1 || bus_out2 !== data[order[g]] || gnt2 !== 3'b000) begin
                n_err++;
                $display("FAIL sw_beat%0d: v=%b bus=%h gnt=%b, want 1 %h 000", g, bus_valid2, bus_out2, gnt2,
                         data[order[g]]);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_burst();
        test_round_robin();
        test_fixed_priority();
        test_early_release();
        test_async_reset();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
